decoder_addr_sequencer: RTL
===========================

Name: decoder_addr_sequencer

Overview:
- Upstream stage for the 5-to-32 decoder. Generates the 5-bit select address A that drives the decoder input.
- Steps A through a programmable address window, holding each address for a programmable dwell time.
- Supports single-pass or continuous scanning. Uses a start/busy/done handshake with abort.
- Replaces hand-timed address stepping, so every decoder line is exercised deterministically in hardware.

Parameters:
- ADDR_W, 5, address width; the decoder has 2**ADDR_W lines.
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
- stop  input  1  abort request; honoured in any state.
- first_addr  input  ADDR_W  first address of the window.
- last_addr  input  ADDR_W  last address of the window.
- dwell  input  DWELL_W  cycles to hold each address; 0 is treated as 1.
- continuous  input  1  1 = wrap from last_addr back to first_addr forever; 0 = single pass.
- A  output  ADDR_W  registered address to the decoder input.
- a_valid  output  1  A is a live scan address; downstream gates decoder output with this.
- step_strobe  output  1  one-cycle pulse in the first cycle each new A is presented.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when a single pass completes normally.

Behaviour:
- Reset (async, rst=1): state=IDLE, A=0, a_valid=0, step_strobe=0, busy=0, done=0, dwell counter=0. Outputs hold these values until rst deasserts.
- States:
  - IDLE -> SCAN on start=1 && stop=0.
  - SCAN -> IDLE on stop, or at the end of the final dwell when continuous=0.
- Start (IDLE, start=1):
  - first_addr, last_addr, dwell and continuous are latched.
  - Latency 1: the next cycle has A=first_addr, a_valid=1, busy=1, step_strobe=1.
  - Input changes during SCAN are ignored.
- Dwell: each address is held for D = max(dwell,1) cycles. step_strobe is high only in the first of those cycles.
- Advance at the end of a dwell:
  - If A != last, then A <= (A+1) mod 2**ADDR_W. This wraps 31->0, so first_addr > last_addr scans across the top (e.g. 30,31,0,1).
  - If A == last and continuous=1, then A <= first (step_strobe pulses again).
  - If A == last and continuous=0, then the next cycle has state=IDLE, a_valid=0, busy=0, done=1 for one cycle, and A keeps its last value.
- Pass length: ((last-first) mod 2**ADDR_W)+1 addresses. first==last gives one address.
- stop in SCAN: the next cycle has IDLE, a_valid=0, busy=0, and no done pulse. A keeps its value.
- Simultaneous events:
  - stop and start in the same IDLE cycle: stop wins and the block stays IDLE.
  - stop on the final dwell cycle: abort wins and no done pulse is issued.
  - start while busy: ignored.
- Reset mid-scan: immediate return to the reset values; no done pulse.
- a_valid=0 at all times outside SCAN.

Optional Feature:
- Macro DEC_SEQ_REVERSE_EN.
- When defined:
  - Adds input port dir (1 bit), latched on start.
  - dir=1 scans descending: A <= (A-1) mod 2**ADDR_W. Termination is still at A==last, and the pass length becomes ((first-last) mod 2**ADDR_W)+1.
- When undefined:
  - No dir port exists and scanning is ascending only.
  - The RTL must be identical to dir=0 behaviour.

Decomposition:
- Shared package dec_pkg holds:
  - ADDR_W=5 and NUM_LINES=32 constants, shared with the decoder.
  - the seq_state_t enum {IDLE, SCAN}.
  - an address type addr_t = logic [ADDR_W-1:0].
- One sub-module, dec_dwell_timer:
  - Inputs: load, dwell.
  - Output: expire, a one-cycle pulse after max(dwell,1) cycles.
  - Reloads on every address advance.

Test Plan:
- Reset: assert rst mid-cycle, with no clock edge needed -> A=0, a_valid=0, busy=0, done=0 immediately.
- Single pass:
  - Stimulus: first=0, last=31, dwell=0, continuous=0.
  - Response: A=0..31 on consecutive cycles with step_strobe every cycle. done pulses once, 33 cycles after start. Every decoder output line Y[i] is seen high exactly once.
- Wrap window:
  - Stimulus: first=30, last=1, dwell=3.
  - Response: A sequence 30,31,0,1, each held 3 cycles; done at cycle 13 after start.
- Continuous plus abort:
  - Stimulus: first=4, last=6, dwell=2, continuous=1; pulse stop after 10 cycles.
  - Response: A runs 4,4,5,5,6,6,4,4,5,5. The next cycle has a_valid=0 and busy=0, with no done pulse.
- Conflicts:
  - start while busy -> no effect on A.
  - start and stop together in IDLE -> stays IDLE.
  - stop on the last dwell cycle -> no done pulse.
- DEC_SEQ_REVERSE_EN defined:
  - Stimulus: dir=1, first=2, last=30, dwell=1.
  - Response: A sequence 2,1,0,31,30; done after 5 addresses.

Source files
------------

// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared constants and types for the decoder address path
package dec_pkg;
    localparam int ADDR_W    = 5;
    localparam int NUM_LINES = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } seq_state_t;
endpackage

// File: rtl/dec_dwell_timer.sv
// rtl/dec_dwell_timer.sv - per-address dwell countdown; expire marks the last dwell cycle
module dec_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expire
);
    logic [DWELL_W-1:0] r_cnt;

    // A dwell of 0 behaves as 1, so both load a zero remaining count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= (dwell == '0) ? '0 : dwell - 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expire = (r_cnt == '0);
endmodule

// File: rtl/decoder_addr_sequencer.sv
// rtl/decoder_addr_sequencer.sv - windowed address scanner feeding the 5-to-32 decoder
// Optional descending scan via `define DEC_SEQ_REVERSE_EN (adds input dir).
module decoder_addr_sequencer
    import dec_pkg::seq_state_t;
    import dec_pkg::IDLE;
    import dec_pkg::SCAN;
#(
    parameter int ADDR_W  = 5,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [ADDR_W-1:0]  first_addr,
    input  logic [ADDR_W-1:0]  last_addr,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               continuous,
`ifdef DEC_SEQ_REVERSE_EN
    input  logic               dir,
`endif
    output logic [ADDR_W-1:0]  A,
    output logic               a_valid,
    output logic               step_strobe,
    output logic               busy,
    output logic               done
);
    seq_state_t         r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_a, w_a_nxt, w_a_step;
    logic [ADDR_W-1:0]  r_first, r_last;
    logic [DWELL_W-1:0] r_dwell, w_dwell_src;
    logic               r_cont, r_strobe, r_done;
    logic               w_strobe_nxt, w_done_nxt, w_load, w_expire, w_accept;

    assign w_accept = (r_state == IDLE) && start && !stop;

`ifdef DEC_SEQ_REVERSE_EN
    logic r_dir;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir <= 1'b0;
        end else if (w_accept) begin
            r_dir <= dir;
        end
    end
    assign w_a_step = r_dir ? r_a - 1'b1 : r_a + 1'b1;
`else
    assign w_a_step = r_a + 1'b1;
`endif

    // The first dwell is loaded on the start edge, before the window is latched.
    assign w_dwell_src = (r_state == IDLE) ? dwell : r_dwell;

    dec_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .dwell  (w_dwell_src),
        .expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_first  <= '0;
            r_last   <= '0;
            r_dwell  <= '0;
            r_cont   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_strobe <= w_strobe_nxt;
            r_done   <= w_done_nxt;
            if (w_accept) begin
                r_first <= first_addr;
                r_last  <= last_addr;
                r_dwell <= dwell;
                r_cont  <= continuous;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = SCAN;
                    w_a_nxt      = first_addr;
                    w_strobe_nxt = 1'b1;
                    w_load       = 1'b1;
                end
            end
            SCAN: begin
                // Abort takes priority over completing the pass.
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_expire) begin
                    if (r_a != r_last) begin
                        w_a_nxt      = w_a_step;
                        w_strobe_nxt = 1'b1;
                        w_load       = 1'b1;
                    end else if (r_cont) begin
                        w_a_nxt      = r_first;
                        w_strobe_nxt = 1'b1;
                        w_load       = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign A           = r_a;
    assign a_valid     = (r_state == SCAN);
    assign busy        = (r_state == SCAN);
    assign step_strobe = r_strobe;
    assign done        = r_done;
endmodule
